lagarto_dcache_spm_responder: RTL and testbench



---
 rtl/drac_pkg.sv | 46 ++++
 rtl/lagarto_spm_sram.sv | 30 +++
 rtl/lagarto_dcache_spm_responder.sv | 167 ++++++++++++++++
 tb/tb_lagarto_dcache_spm_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared types for the Lagarto dcache scratchpad responder: access sizes,
// load FSM states, default address widths and lane alignment helpers.
package drac_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH_DEF = 12;
  localparam int unsigned DCACHE_TAG_WIDTH_DEF   = 44;
  localparam int unsigned MEM_WORDS_DEF          = 4096;
  localparam int unsigned PADDR_W    = DCACHE_INDEX_WIDTH_DEF + DCACHE_TAG_WIDTH_DEF;
  localparam int unsigned MEM_ADDR_W = $clog2(MEM_WORDS_DEF) + 3;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_TAG  = 2'd1,
    L_RESP = 2'd2
  } ld_state_e;

  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

  // Moves the addressed lane down to bit 0 and zero-extends to the access size.
  function automatic logic [63:0] load_align(input logic [63:0] word, input logic [2:0] off,
                                             input logic [1:0] size);
    logic [63:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_B:  return {56'd0, sh[7:0]};
      SIZE_H:  return {48'd0, sh[15:0]};
      SIZE_W:  return {32'd0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/lagarto_spm_sram.sv
// Single-port 64-bit scratchpad RAM with byte write enables and a
// registered read port (data valid the cycle after re_i).
module lagarto_spm_sram #(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  input  logic [7:0]    be_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [WORDS];
  logic [63:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lagarto_dcache_spm_responder.sv
// Responder side of the Lagarto core-to-dcache protocol backed by a 64-bit
// scratchpad. Stores complete in one phase; loads use an index/tag FSM.
module lagarto_dcache_spm_responder
  import drac_pkg::*;
#(
  parameter int unsigned DCACHE_INDEX_WIDTH = 12,
  parameter int unsigned DCACHE_TAG_WIDTH   = 44,
  parameter int unsigned MEM_WORDS          = 4096,
  parameter logic [63:0] BASE_ADDR          = 64'h0000_0000_8000_0000
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [DCACHE_INDEX_WIDTH-1:0] ld_mem_req_addr_index_i,
  input  logic [DCACHE_TAG_WIDTH-1:0]   ld_mem_req_addr_tag_i,
  input  logic                          ld_mem_req_valid_i,
  input  logic                          ld_mem_req_tag_valid_i,
  input  logic                          ld_mem_req_kill_i,
  input  logic [1:0]                    ld_mem_req_size_i,
  input  logic [DCACHE_INDEX_WIDTH-1:0] st_mem_req_addr_index_i,
  input  logic [DCACHE_TAG_WIDTH-1:0]   st_mem_req_addr_tag_i,
  input  logic [63:0]                   st_mem_req_wdata_i,
  input  logic                          st_mem_req_valid_i,
  input  logic                          st_mem_req_we_i,
  input  logic [7:0]                    st_mem_req_be_i,
  input  logic [1:0]                    st_mem_req_size_i,
  input  logic                          st_mem_req_kill_i,
  input  logic                          st_mem_req_tag_valid_i,
  output logic [63:0]                   dmem_resp_data_o,
  output logic                          dmem_resp_valid_o,
  output logic                          dmem_resp_nack_o,
  output logic                          dmem_xcpt_ma_st_o,
  output logic                          dmem_xcpt_ma_ld_o,
  output logic                          dmem_xcpt_pf_st_o,
  output logic                          dmem_xcpt_pf_ld_o
);

  localparam int unsigned PA_W = DCACHE_INDEX_WIDTH + DCACHE_TAG_WIDTH;
  localparam int unsigned MA_W = $clog2(MEM_WORDS) + 3;
  localparam int unsigned WA_W = MA_W - 3;
  localparam logic [PA_W-1:0] BASE_P = BASE_ADDR[PA_W-1:0];

  // Base is region-aligned, so every bit above the scratchpad offset must match.
  function automatic logic in_region(input logic [PA_W-1:0] paddr);
    return paddr[PA_W-1:MA_W] == BASE_P[PA_W-1:MA_W];
  endfunction

  ld_state_e                     state_q, state_d;
  logic [DCACHE_INDEX_WIDTH-1:0] ld_index_q, ld_index_d;
  mem_size_e                     ld_size_q, ld_size_d;
  logic st_ack_q, st_ack_d, st_ma_q, st_ma_d, st_pf_q, st_pf_d;
  logic ld_ma_q, ld_ma_d, ld_pf_q, ld_pf_d, nack_q, nack_d;

  logic [PA_W-1:0] st_paddr, ld_paddr;
  logic            st_fire, st_ma, st_write, ld_read;
  logic [WA_W-1:0] ram_addr;
  logic [63:0]     ram_rdata;

  assign st_paddr = {st_mem_req_addr_tag_i, st_mem_req_addr_index_i};
  assign ld_paddr = {ld_mem_req_addr_tag_i, ld_index_q};

  assign st_fire  = st_mem_req_valid_i & st_mem_req_tag_valid_i & st_mem_req_we_i
                  & ~st_mem_req_kill_i;
  assign st_ma    = is_misaligned(st_paddr[2:0], st_mem_req_size_i);
  assign st_write = st_fire & ~st_ma & in_region(st_paddr);

  always_comb begin
    st_ack_d = st_write;
    st_ma_d  = st_fire & st_ma;
    st_pf_d  = st_fire & ~st_ma & ~in_region(st_paddr);
  end

  always_comb begin
    state_d    = state_q;
    ld_index_d = ld_index_q;
    ld_size_d  = ld_size_q;
    ld_read    = 1'b0;
    ld_ma_d    = 1'b0;
    ld_pf_d    = 1'b0;
    nack_d     = 1'b0;
    case (state_q)
      L_IDLE: begin
        if (ld_mem_req_valid_i) begin
          ld_index_d = ld_mem_req_addr_index_i;
          ld_size_d  = mem_size_e'(ld_mem_req_size_i);
          state_d    = L_TAG;
        end
      end
      L_TAG: begin
        nack_d = ld_mem_req_valid_i;
        if (ld_mem_req_kill_i) begin
          state_d = L_IDLE;
        end else if (ld_mem_req_tag_valid_i) begin
          if (is_misaligned(ld_index_q[2:0], ld_size_q)) begin
            ld_ma_d = 1'b1;
            state_d = L_IDLE;
          end else if (!in_region(ld_paddr)) begin
            ld_pf_d = 1'b1;
            state_d = L_IDLE;
          end else if (!st_write) begin
            // A store owning the RAM this cycle pushes the read out by one cycle.
            ld_read = 1'b1;
            state_d = L_RESP;
          end
        end
      end
      L_RESP: begin
        if (ld_mem_req_valid_i) begin
          ld_index_d = ld_mem_req_addr_index_i;
          ld_size_d  = mem_size_e'(ld_mem_req_size_i);
          state_d    = L_TAG;
        end else begin
          state_d = L_IDLE;
        end
      end
      default: state_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= L_IDLE;
      ld_index_q <= '0;
      ld_size_q  <= SIZE_B;
      st_ack_q   <= 1'b0;
      st_ma_q    <= 1'b0;
      st_pf_q    <= 1'b0;
      ld_ma_q    <= 1'b0;
      ld_pf_q    <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_index_q <= ld_index_d;
      ld_size_q  <= ld_size_d;
      st_ack_q   <= st_ack_d;
      st_ma_q    <= st_ma_d;
      st_pf_q    <= st_pf_d;
      ld_ma_q    <= ld_ma_d;
      ld_pf_q    <= ld_pf_d;
      nack_q     <= nack_d;
    end
  end

  assign ram_addr = st_write ? st_paddr[MA_W-1:3] : ld_paddr[MA_W-1:3];

  lagarto_spm_sram #(
    .WORDS (MEM_WORDS),
    .AW    (WA_W)
  ) u_sram (
    .clk_i   (clk_i),
    .we_i    (st_write),
    .re_i    (ld_read),
    .addr_i  (ram_addr),
    .wdata_i (st_mem_req_wdata_i),
    .be_i    (st_mem_req_be_i),
    .rdata_o (ram_rdata)
  );

  assign dmem_resp_valid_o = st_ack_q | (state_q == L_RESP);
  assign dmem_resp_data_o  = (state_q == L_RESP) ? load_align(ram_rdata, ld_index_q[2:0], ld_size_q)
                                                 : 64'd0;
  assign dmem_resp_nack_o  = nack_q;
  assign dmem_xcpt_ma_st_o = st_ma_q;
  assign dmem_xcpt_ma_ld_o = ld_ma_q;
  assign dmem_xcpt_pf_st_o = st_pf_q;
  assign dmem_xcpt_pf_ld_o = ld_pf_q;

endmodule

// File: tb/tb_lagarto_dcache_spm_responder.sv
// Bench for lagarto_dcache_spm_responder: a vector table of single accesses,
// hand-written stall/kill/reset sequences and a cycle-stamped response scoreboard.
module tb_lagarto_dcache_spm_responder;

  localparam int EW = 32 + 6 + 64;
  localparam logic [5:0] F_VALID = 6'b100000;
  localparam logic [5:0] F_NACK  = 6'b010000;
  localparam logic [5:0] F_MA_ST = 6'b001000;
  localparam logic [5:0] F_MA_LD = 6'b000100;
  localparam logic [5:0] F_PF_ST = 6'b000010;
  localparam logic [5:0] F_PF_LD = 6'b000001;

  logic        clk, rstn;
  logic [11:0] ld_index, st_index;
  logic [43:0] ld_tag, st_tag;
  logic        ld_valid, ld_tag_valid, ld_kill;
  logic [1:0]  ld_size, st_size;
  logic [63:0] st_wdata;
  logic        st_valid, st_we, st_kill, st_tag_valid;
  logic [7:0]  st_be;
  logic [63:0] resp_data;
  logic        resp_valid, resp_nack, ma_st, ma_ld, pf_st, pf_ld;
  logic [69:0] outs;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic        is_st;
    logic [55:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [5:0]  flags;
    logic [63:0] data;
  } vec_t;
  vec_t vq[$];

  lagarto_dcache_spm_responder dut (
    .clk_i                   (clk),
    .rstn_i                  (rstn),
    .ld_mem_req_addr_index_i (ld_index),
    .ld_mem_req_addr_tag_i   (ld_tag),
    .ld_mem_req_valid_i      (ld_valid),
    .ld_mem_req_tag_valid_i  (ld_tag_valid),
    .ld_mem_req_kill_i       (ld_kill),
    .ld_mem_req_size_i       (ld_size),
    .st_mem_req_addr_index_i (st_index),
    .st_mem_req_addr_tag_i   (st_tag),
    .st_mem_req_wdata_i      (st_wdata),
    .st_mem_req_valid_i      (st_valid),
    .st_mem_req_we_i         (st_we),
    .st_mem_req_be_i         (st_be),
    .st_mem_req_size_i       (st_size),
    .st_mem_req_kill_i       (st_kill),
    .st_mem_req_tag_valid_i  (st_tag_valid),
    .dmem_resp_data_o        (resp_data),
    .dmem_resp_valid_o       (resp_valid),
    .dmem_resp_nack_o        (resp_nack),
    .dmem_xcpt_ma_st_o       (ma_st),
    .dmem_xcpt_ma_ld_o       (ma_ld),
    .dmem_xcpt_pf_st_o       (pf_st),
    .dmem_xcpt_pf_ld_o       (pf_ld)
  );

  assign outs = {resp_valid, resp_nack, ma_st, ma_ld, pf_st, pf_ld, resp_data};

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: bench still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [69:0] got, input logic [69:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Cycle-sorted insert; expectations landing on the same cycle are merged.
  task automatic push_exp(input int at, input logic [5:0] flags, input logic [63:0] data);
    logic [EW-1:0] e;
    e = {32'(at), flags, data};
    for (int i = 0; i < exp_q.size(); i++) begin
      if (int'(exp_q[i][101:70]) == at) begin
        e = exp_q[i];
        e[69:0] = e[69:0] | {flags, data};
        exp_q[i] = e;
        return;
      end
      if (int'(exp_q[i][101:70]) > at) begin
        exp_q.insert(i, e);
        return;
      end
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rstn) begin
      while (exp_q.size() > 0 && int'(exp_q[0][101:70]) < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_resp: got nothing at cycle %0d required flags=%b data=%h",
                 int'(e[101:70]), e[69:64], e[63:0]);
      end
      if (outs != 70'd0) begin
        checks++;
        if (exp_q.size() == 0 || int'(exp_q[0][101:70]) != cyc) begin
          errors++;
          $display("FAIL unexpected_resp: got flags=%b data=%h at cycle %0d required no output",
                   outs[69:64], outs[63:0], cyc);
        end else begin
          e = exp_q.pop_front();
          if (e[69:0] !== outs) begin
            errors++;
            $display("FAIL resp_cycle_%0d: got flags=%b data=%h required flags=%b data=%h",
                     cyc, outs[69:64], outs[63:0], e[69:64], e[63:0]);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic step_clear();
    @(posedge clk);
    #1;
    ld_valid = 1'b0; ld_tag_valid = 1'b0; ld_kill = 1'b0;
    st_valid = 1'b0; st_tag_valid = 1'b0; st_kill = 1'b0;
  endtask

  task automatic drive_store(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be,
                             input logic [1:0] sz);
    st_index = a[11:0]; st_tag = a[55:12]; st_wdata = d; st_be = be; st_size = sz;
    st_valid = 1'b1; st_tag_valid = 1'b1; st_we = 1'b1;
  endtask

  task automatic drive_ld_index(input logic [55:0] a, input logic [1:0] sz);
    ld_index = a[11:0]; ld_size = sz; ld_valid = 1'b1;
  endtask

  task automatic drive_ld_tag(input logic [55:0] a);
    ld_tag = a[55:12]; ld_tag_valid = 1'b1;
  endtask

  task automatic run_store(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be,
                           input logic [1:0] sz, input logic [5:0] flags);
    drive_store(a, d, be, sz);
    push_exp(cyc + 1, flags, 64'd0);
    step_clear();
    repeat (2) step_clear();
  endtask

  task automatic run_load(input logic [55:0] a, input logic [1:0] sz, input logic [5:0] flags,
                          input logic [63:0] data);
    drive_ld_index(a, sz);
    step_clear();
    drive_ld_tag(a);
    push_exp(cyc + 1, flags, data);
    step_clear();
    repeat (2) step_clear();
  endtask

  task automatic add_vec(input logic is_st, input logic [55:0] a, input logic [1:0] sz,
                         input logic [63:0] wd, input logic [7:0] be, input logic [5:0] flags,
                         input logic [63:0] data);
    vec_t v;
    v.is_st = is_st; v.addr = a; v.size = sz; v.wdata = wd; v.be = be;
    v.flags = flags; v.data = data;
    vq.push_back(v);
  endtask

  initial begin
    logic [55:0] a;
    logic [63:0] d, want;
    int w, sz, off;

    rstn = 1'b0;
    ld_index = '0; ld_tag = '0; ld_valid = 0; ld_tag_valid = 0; ld_kill = 0; ld_size = 0;
    st_index = '0; st_tag = '0; st_wdata = '0; st_valid = 0; st_we = 0; st_be = '0;
    st_size = 0; st_kill = 0; st_tag_valid = 0;

    add_vec(1, 56'h8000_0010, 2'd3, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, F_VALID, 64'd0);
    add_vec(0, 56'h8000_0010, 2'd3, 64'd0, 8'h00, F_VALID, 64'hDEAD_BEEF_CAFE_F00D);
    add_vec(0, 56'h8000_0013, 2'd0, 64'd0, 8'h00, F_VALID, 64'h0000_0000_0000_00CA);
    add_vec(0, 56'h8000_0014, 2'd0, 64'd0, 8'h00, F_VALID, 64'h0000_0000_0000_00EF);
    add_vec(0, 56'h8000_0016, 2'd1, 64'd0, 8'h00, F_VALID, 64'h0000_0000_0000_DEAD);
    add_vec(0, 56'h8000_0014, 2'd2, 64'd0, 8'h00, F_VALID, 64'h0000_0000_DEAD_BEEF);
    add_vec(0, 56'h8000_0012, 2'd2, 64'd0, 8'h00, F_MA_LD, 64'd0);
    add_vec(1, 56'h8000_1000, 2'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, F_VALID, 64'd0);
    add_vec(1, 56'h0000_1000, 2'd2, 64'h0000_0000_5555_5555, 8'h0F, F_PF_ST, 64'd0);
    add_vec(0, 56'h8000_1000, 2'd3, 64'd0, 8'h00, F_VALID, 64'h0123_4567_89AB_CDEF);
    add_vec(1, 56'h8000_0011, 2'd1, 64'h0000_0000_0077_7700, 8'h06, F_MA_ST, 64'd0);
    add_vec(0, 56'h8000_0010, 2'd3, 64'd0, 8'h00, F_VALID, 64'hDEAD_BEEF_CAFE_F00D);
    add_vec(1, 56'h8000_0011, 2'd0, 64'h0000_0000_0000_5500, 8'h02, F_VALID, 64'd0);
    add_vec(0, 56'h8000_0010, 2'd3, 64'd0, 8'h00, F_VALID, 64'hDEAD_BEEF_CAFE_550D);
    add_vec(1, 56'h8000_7FF8, 2'd3, 64'h0F1E_2D3C_4B5A_6978, 8'hFF, F_VALID, 64'd0);
    add_vec(0, 56'h8000_7FF8, 2'd3, 64'd0, 8'h00, F_VALID, 64'h0F1E_2D3C_4B5A_6978);
    add_vec(1, 56'h8000_0000, 2'd3, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, F_VALID, 64'd0);
    add_vec(1, 56'h8000_8000, 2'd3, 64'h1111_1111_1111_1111, 8'hFF, F_PF_ST, 64'd0);
    add_vec(1, 56'h01_8000_0000, 2'd3, 64'h2222_2222_2222_2222, 8'hFF, F_PF_ST, 64'd0);
    add_vec(0, 56'h8000_0000, 2'd3, 64'd0, 8'h00, F_VALID, 64'hA5A5_A5A5_5A5A_5A5A);
    add_vec(0, 56'h7FFF_FFF8, 2'd3, 64'd0, 8'h00, F_PF_LD, 64'd0);
    add_vec(0, 56'h8000_8000, 2'd2, 64'd0, 8'h00, F_PF_LD, 64'd0);
    add_vec(1, 56'h0000_0001, 2'd1, 64'h0000_0000_0000_3300, 8'h06, F_MA_ST, 64'd0);
    add_vec(0, 56'h0000_0003, 2'd2, 64'd0, 8'h00, F_MA_LD, 64'd0);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", outs, 70'd0);
    rstn = 1'b1;
    step_clear();

    foreach (vq[i]) begin
      if (vq[i].is_st) run_store(vq[i].addr, vq[i].wdata, vq[i].be, vq[i].size, vq[i].flags);
      else             run_load(vq[i].addr, vq[i].size, vq[i].flags, vq[i].data);
    end

    // Random word round trips against a byte-level extraction model
    for (int k = 0; k < 6; k++) begin
      w = $urandom_range(256, 511);
      a = 56'h8000_0000 + 56'(w * 8);
      d = {$urandom, $urandom};
      run_store(a, d, 8'hFF, 2'd3, F_VALID);
      sz  = $urandom_range(0, 3);
      off = $urandom_range(0, 7) & ~((1 << sz) - 1);
      want = 64'd0;
      for (int b = 0; b < (1 << sz); b++) want[b*8 +: 8] = d[(off + b)*8 +: 8];
      run_load(a + 56'(off), 2'(sz), F_VALID, want);
    end

    // Tag phase collides with a store, then a second index arrives while stalled
    a = 56'h8000_0020;
    drive_ld_index(a, 2'd3);
    step_clear();
    drive_ld_tag(a);
    drive_store(a, 64'h1111_2222_3333_4444, 8'hFF, 2'd3);
    push_exp(cyc + 1, F_VALID, 64'd0);
    step_clear();
    drive_ld_tag(a);
    ld_valid = 1'b1; ld_index = 12'h040; ld_size = 2'd3;
    push_exp(cyc + 1, F_VALID | F_NACK, 64'h1111_2222_3333_4444);
    step_clear();
    repeat (3) step_clear();

    // Killed load: no response
    drive_ld_index(a, 2'd3);
    step_clear();
    drive_ld_tag(a);
    ld_kill = 1'b1;
    step_clear();
    repeat (3) step_clear();

    // Reset while a load waits in the tag phase and a store ack is pending
    drive_ld_index(a, 2'd3);
    step_clear();
    drive_store(56'h8000_0028, 64'h9999_8888_7777_6666, 8'hFF, 2'd3);
    step_clear();
    rstn = 1'b0;
    #1;
    check("reset_async_outputs", outs, 70'd0);
    repeat (2) begin
      @(negedge clk);
      check("reset_held_outputs", outs, 70'd0);
    end
    rstn = 1'b1;
    step_clear();
    drive_ld_tag(a);
    step_clear();
    repeat (3) step_clear();

    run_load(56'h8000_0020, 2'd3, F_VALID, 64'h1111_2222_3333_4444);
    run_load(56'h8000_0028, 2'd3, F_VALID, 64'h9999_8888_7777_6666);

    repeat (4) step_clear();
    check("scoreboard_drained", 70'(exp_q.size()), 70'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
